// File: rtl/approx_umul_pipe_if.sv
// Operand and result handshake bundle for approx_umul_pipe.
// The master drives operands and out_ready; the slave (the multiplier) answers.
interface approx_umul_pipe_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           in_approx;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_z;

  modport master (
    output in_valid, in_x, in_y, in_approx, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_x, in_y, in_approx, out_ready,
    output in_ready, out_valid, out_z
  );
endinterface

// File: rtl/approx_umul_pipe.sv
// Two-stage pipelined WxW unsigned multiplier with per-operand exact/approximate mode.
// Optional macro APPROX_COMP_EN adds OR-compressed rounding of the first dropped column.
module approx_umul_pipe #(
  parameter int W   = 8,
  parameter int L   = 4,
  parameter int CUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  approx_umul_pipe_if.slave   bus,
  output logic [31:0]         op_count
);

  localparam int ZW = 2 * W;
  localparam logic [ZW-1:0] KEEP_MASK = {ZW{1'b1}} << CUT;

  // ---------------------------------------------------------------
  // Stage-1 arithmetic: exact high rows, exact and truncated low rows
  // ---------------------------------------------------------------
  logic [ZW-1:0] row_pp [L];
  logic [ZW-1:0] hi_prod;
  logic [ZW-1:0] lo_exact;
  logic [ZW-1:0] lo_trunc;
  logic [ZW-1:0] lo_approx;
  logic [ZW-1:0] lo_sel;

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_row
      assign row_pp[gi] = bus.in_x[gi] ? (ZW'(bus.in_y) << gi) : '0;
    end
  endgenerate

  assign hi_prod = (ZW'(bus.in_y) * ZW'(bus.in_x[W-1:L])) << L;

  always_comb begin
    lo_exact = '0;
    lo_trunc = '0;
    for (int i = 0; i < L; i++) begin
      lo_exact = lo_exact + row_pp[i];
      lo_trunc = lo_trunc + (row_pp[i] & KEEP_MASK);
    end
  end

`ifdef APPROX_COMP_EN
  // Any set bit in column CUT-1 of the low rows rounds up by half an LSB of the kept part.
  localparam logic [ZW-1:0] COMP_TERM = {{(ZW-1){1'b0}}, 1'b1} << (CUT - 1);
  logic [L-1:0] row_edge;

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_edge
      assign row_edge[gi] = row_pp[gi][CUT-1];
    end
  endgenerate

  assign lo_approx = lo_trunc + ((|row_edge) ? COMP_TERM : '0);
`else
  assign lo_approx = lo_trunc;
`endif

  assign lo_sel = bus.in_approx ? lo_approx : lo_exact;

  // ---------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------
  logic          s1_valid_q, s1_valid_d;
  logic [ZW-1:0] hi_q, hi_d;
  logic [ZW-1:0] lo_q, lo_d;
  logic          s2_valid_q, s2_valid_d;
  logic [ZW-1:0] z_q, z_d;
  logic [31:0]   op_count_q, op_count_d;
  logic          s1_adv;
  logic          s2_adv;

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        hi_d = hi_prod;
        lo_d = lo_sel;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        z_d = hi_q + lo_q;
      end
    end
  end

  // Wraps naturally at 2^32.
  always_comb begin
    op_count_d = op_count_q;
    if (s2_valid_q && bus.out_ready) begin
      op_count_d = op_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_z     = z_q;
  assign op_count      = op_count_q;

endmodule
